reg_unit: RTL and testbench

- Small synchronous register file: REG_DEPTH words of REG_WIDTH bits, one shared address bus, separate write and read enables.
- Used as a generic configuration/scratch register bank in the datapath.
- Writes land at the clock edge; reads return data through a registered output one cycle after the read request.

---
 rtl/reg_unit_pkg.sv | 10 +
 rtl/reg_unit.sv | 68 ++++++
 tb/tb_reg_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/reg_unit_pkg.sv
// rtl/reg_unit_pkg.sv - default sizing constants and word type for reg_unit
package reg_unit_pkg;

  localparam int REG_WIDTH_DEF  = 16;
  localparam int REG_DEPTH_DEF  = 8;
  localparam int ADDR_WIDTH_DEF = 3;

  typedef logic [REG_WIDTH_DEF-1:0] reg_word_t;

endpackage

// File: rtl/reg_unit.sv
// rtl/reg_unit.sv - REG_DEPTH x REG_WIDTH register bank with registered read port
// Optional RdValid output enabled by macro REG_UNIT_RD_VALID_EN.
module reg_unit
  import reg_unit_pkg::*;
#(
  parameter int REG_WIDTH  = REG_WIDTH_DEF,
  parameter int REG_DEPTH  = REG_DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WrEn,
  input  logic                  RdEn,
  input  logic [REG_WIDTH-1:0]  WrData,
  input  logic [ADDR_WIDTH-1:0] Address,
  output logic [REG_WIDTH-1:0]  RdData
`ifdef REG_UNIT_RD_VALID_EN
  ,
  output logic                  RdValid
`endif
);

  logic [REG_WIDTH-1:0] r_mem [REG_DEPTH];
  logic [REG_WIDTH-1:0] r_rd_data;
  logic                 w_in_range;
  logic                 w_wr;
  logic                 w_rd;

  assign w_in_range = (int'(Address) < REG_DEPTH);
  // A simultaneous write and read performs only the write.
  assign w_wr = WrEn && w_in_range;
  assign w_rd = RdEn && !WrEn;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < REG_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem[Address] <= WrData;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_data <= '0;
    end else if (w_rd) begin
      r_rd_data <= w_in_range ? r_mem[Address] : '0;
    end
  end

  assign RdData = r_rd_data;

`ifdef REG_UNIT_RD_VALID_EN
  logic r_rd_valid;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
    end
  end

  assign RdValid = r_rd_valid;
`endif

endmodule

// File: tb/tb_reg_unit.sv
// tb/tb_reg_unit.sv - directed table-driven bench for reg_unit
// Also checks RdValid when REG_UNIT_RD_VALID_EN is defined.
module tb_reg_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        WrEn = 1'b0;
  logic        RdEn = 1'b0;
  logic [15:0] WrData = '0;
  logic [2:0]  Address = '0;
  logic [15:0] RdData;
`ifdef REG_UNIT_RD_VALID_EN
  logic        RdValid;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        wr;
    logic        rd;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic        exp_valid;
    string       name;
  } vec_t;

  vec_t vecs[$];
  logic [15:0] model [8];

  reg_unit dut (
    .CLK    (CLK),
    .RST    (RST),
    .WrEn   (WrEn),
    .RdEn   (RdEn),
    .WrData (WrData),
    .Address(Address),
    .RdData (RdData)
`ifdef REG_UNIT_RD_VALID_EN
    ,
    .RdValid(RdValid)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic add(input logic rst, input logic wr, input logic rd, input logic [2:0] addr,
                     input logic [15:0] wdata, input logic [15:0] exp_rd, input logic exp_valid,
                     input string name);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_valid = exp_valid; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic step(input logic rst, input logic wr, input logic rd, input logic [2:0] addr,
                      input logic [15:0] wdata);
    RST = rst; WrEn = wr; RdEn = rd; Address = addr; WrData = wdata;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] exp_rd, input logic exp_valid);
    checks++;
    if (RdData !== exp_rd) begin
      errors++;
      $display("FAIL %s: RdData=%h expected %h", name, RdData, exp_rd);
    end
`ifdef REG_UNIT_RD_VALID_EN
    checks++;
    if (RdValid !== exp_valid) begin
      errors++;
      $display("FAIL %s: RdValid=%b expected %b", name, RdValid, exp_valid);
    end
`else
    if (exp_valid === 1'bx) $display("unused");
`endif
  endtask

  initial begin
    add(1, 0, 0, 0, 16'h0000, 16'h0000, 0, "reset");
    for (int i = 0; i < 8; i++) add(0, 0, 1, 3'(i), 16'h0, 16'h0000, 1, "read_after_reset");
    add(0, 1, 0, 5, 16'h0007, 16'h0000, 0, "write5");
    add(0, 0, 1, 5, 16'h0000, 16'h0007, 1, "read5");
    add(0, 1, 0, 7, 16'h000F, 16'h0007, 0, "write7");
    add(0, 0, 1, 7, 16'h0000, 16'h000F, 1, "read7");
    for (int i = 0; i < 3; i++) add(0, 0, 0, 3'(i), 16'h1234, 16'h000F, 0, "idle_hold");
    add(0, 0, 1, 5, 16'h0000, 16'h0007, 1, "read5_isolation");
    add(0, 0, 1, 7, 16'h0000, 16'h000F, 1, "read7_again");
    add(0, 1, 1, 2, 16'hBEEF, 16'h000F, 0, "simul_wr_rd_hold");
    add(0, 0, 1, 2, 16'h0000, 16'hBEEF, 1, "read2_after_simul");
    add(0, 1, 0, 4, 16'h1111, 16'hBEEF, 0, "write4_first");
    add(0, 1, 0, 4, 16'h2222, 16'hBEEF, 0, "write4_second");
    add(0, 0, 1, 4, 16'h0000, 16'h2222, 1, "last_write_wins");
    add(0, 1, 0, 3, 16'hAAAA, 16'h2222, 0, "write3");
    add(1, 1, 0, 3, 16'h5555, 16'h0000, 0, "reset_mid_write");
    add(0, 0, 1, 3, 16'h0000, 16'h0000, 1, "read3_after_reset");
    add(0, 0, 1, 5, 16'h0000, 16'h0000, 1, "read5_after_reset");
    add(0, 1, 0, 6, 16'hCAFE, 16'h0000, 0, "write6");
    add(1, 0, 1, 6, 16'h0000, 16'h0000, 0, "reset_mid_read");
    add(0, 0, 0, 6, 16'h0000, 16'h0000, 0, "idle_after_reset");

    #2;
    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].wr, vecs[k].rd, vecs[k].addr, vecs[k].wdata);
      check(vecs[k].name, vecs[k].exp_rd, vecs[k].exp_valid);
    end

    // Fill every address from a model, then read back-to-back in reverse order.
    for (int i = 0; i < 8; i++) begin
      model[i] = 16'($urandom);
      step(0, 1, 0, 3'(i), model[i]);
    end
    for (int i = 7; i >= 0; i--) begin
      step(0, 0, 1, 3'(i), 16'h0);
      check("b2b_read", model[i], 1'b1);
    end
    step(0, 0, 0, 0, 16'h0);
    check("valid_drops_after_read", model[0], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, required finish before 50000");
    $fatal(1, "timeout");
  end

endmodule
